// File: rtl/capture_sequencer.sv
// capture_sequencer: controls one logic-analyzer acquisition.
// Gates the sample prescaler, streams probe samples into a circular RAM,
// enforces a pre-trigger history, detects a masked trigger and captures
// a bounded number of post-trigger samples.
module capture_sequencer #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 1024,
  parameter int PRE_SAMPLES = 256
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_arm,
  input  logic                     i_abort,
  input  logic                     i_tick,
  input  logic [WIDTH-1:0]         i_data,
  input  logic [WIDTH-1:0]         i_trig_mask,
  input  logic [WIDTH-1:0]         i_trig_value,
  input  logic [$clog2(DEPTH)-1:0] i_post_count,
  output logic                     o_run,
  output logic                     o_wr_en,
  output logic [$clog2(DEPTH)-1:0] o_wr_addr,
  output logic [WIDTH-1:0]         o_wr_data,
  output logic [$clog2(DEPTH)-1:0] o_trig_addr,
  output logic                     o_busy,
  output logic                     o_done
);

  localparam int AW = $clog2(DEPTH);
  // Largest post count that cannot reach back into the pre-trigger history.
  localparam logic [AW-1:0] POST_MAX = AW'(DEPTH - 1 - PRE_SAMPLES);
  localparam logic [AW-1:0] PRE_LAST = AW'((PRE_SAMPLES > 0) ? PRE_SAMPLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREFILL,
    S_WAIT_TRIG,
    S_POST,
    S_DONE
  } state_t;

  state_t            state_p0;
  state_t            state_nx;

  logic [AW-1:0]     addr_p0;
  logic [AW-1:0]     cnt_p0;
  logic [AW-1:0]     post_cfg_p0;
  logic [WIDTH-1:0]  trig_mask_p0;
  logic [WIDTH-1:0]  trig_value_p0;
  logic [AW-1:0]     trig_addr_p0;

  logic              vld_p1;
  logic [AW-1:0]     wr_addr_p1;
  logic [WIDTH-1:0]  wr_data_p1;

  logic              busy;
  logic              arm_ok;
  logic              tick_ok;
  logic              hit;

  // Saturate the requested post count so the ring never laps the history.
  function automatic logic [AW-1:0] clamp_post(input logic [AW-1:0] n);
    return (n > POST_MAX) ? POST_MAX : n;
  endfunction

  assign busy    = (state_p0 == S_PREFILL) || (state_p0 == S_WAIT_TRIG) ||
                   (state_p0 == S_POST);
  assign arm_ok  = i_arm && !i_abort &&
                   ((state_p0 == S_IDLE) || (state_p0 == S_DONE));
  assign tick_ok = i_tick && busy && !i_abort;
  assign hit     = ((i_data ^ trig_value_p0) & trig_mask_p0) == '0;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_p0 <= S_IDLE;
    else       state_p0 <= state_nx;
  end

  // Next-state decision; abort overrides everything including arm.
  always_comb begin
    state_nx = state_p0;
    if (i_abort) begin
      state_nx = S_IDLE;
    end else begin
      case (state_p0)
        S_IDLE, S_DONE: begin
          if (i_arm) state_nx = (PRE_SAMPLES == 0) ? S_WAIT_TRIG : S_PREFILL;
        end
        S_PREFILL: begin
          if (i_tick && (cnt_p0 == PRE_LAST)) state_nx = S_WAIT_TRIG;
        end
        S_WAIT_TRIG: begin
          if (i_tick && hit) state_nx = (post_cfg_p0 == '0) ? S_DONE : S_POST;
        end
        S_POST: begin
          if (i_tick && (cnt_p0 == AW'(1))) state_nx = S_DONE;
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // Status outputs decoded from the current state.
  always_comb begin
    o_run  = busy;
    o_busy = busy;
    o_done = (state_p0 == S_DONE);
  end

  // Config capture, ring address, prefill/post counter and trigger address.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_abort) begin
      addr_p0      <= '0;
      cnt_p0       <= '0;
      trig_addr_p0 <= '0;
    end else if (arm_ok) begin
      addr_p0       <= '0;
      cnt_p0        <= '0;
      trig_mask_p0  <= i_trig_mask;
      trig_value_p0 <= i_trig_value;
      post_cfg_p0   <= clamp_post(i_post_count);
    end else if (tick_ok) begin
      addr_p0 <= addr_p0 + AW'(1);
      case (state_p0)
        S_PREFILL:   cnt_p0 <= cnt_p0 + AW'(1);
        S_WAIT_TRIG: begin
          if (hit) begin
            cnt_p0       <= post_cfg_p0;
            trig_addr_p0 <= addr_p0;
          end
        end
        S_POST:      cnt_p0 <= cnt_p0 - AW'(1);
        default:     cnt_p0 <= cnt_p0;
      endcase
    end
  end

  // ---- stage p1: registered RAM write, one cycle after the tick ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_p1     <= 1'b0;
      wr_addr_p1 <= '0;
      wr_data_p1 <= '0;
    end else begin
      vld_p1 <= tick_ok;
      if (tick_ok) begin
        wr_addr_p1 <= addr_p0;
        wr_data_p1 <= i_data;
      end
    end
  end

  assign o_wr_en     = vld_p1;
  assign o_wr_addr   = wr_addr_p1;
  assign o_wr_data   = wr_data_p1;
  assign o_trig_addr = trig_addr_p0;

endmodule
